// File: rtl/uart_dl_pkg.sv
// Shared constants and state types for the UART download
// packet receiver.
package uart_dl_pkg;

    localparam int PKT_LEN = 35;
    localparam int PAYLOAD_LEN = 32;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        WAIT,
        RECV,
        CHECK,
        WRITE,
        RESP
    } pkt_state_e;

endpackage

// File: rtl/crc16_modbus.sv
// One-byte step of CRC16-MODBUS (reflected 0xA001); the running
// value is registered by the parent.
module crc16_modbus
    import uart_dl_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            if (crc_o[0]) crc_o = (crc_o >> 1) ^ CRC_POLY;
            else          crc_o = crc_o >> 1;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser with a 2-FF input synchroniser and
// mid-bit sampling.
module uart_rx_byte
    import uart_dl_pkg::*;
#(
    parameter int BIT_CYC = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       active_o
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_d, ferr_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                state_d = IDLE;
                valid_d = rx_s;
                ferr_d  = !rx_s;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= rx_s;
            if (clr_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                valid_o <= 1'b0;
                frame_err_o <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                bit_q   <= bit_d;
                shift_q <= shift_d;
                valid_o <= valid_d;
                frame_err_o <= ferr_d;
            end
        end
    end

    assign byte_o   = shift_q;
    assign active_o = (state_q != IDLE);

endmodule

// File: rtl/uart_dl_pkt_rx.sv
// UART download receiver: assembles 35-byte packets, checks CRC
// and sequence, writes the payload to memory and answers ACK/NAK.
module uart_dl_pkt_rx
    import uart_dl_pkg::*;
#(
    parameter int          CLK_FREQ     = 50_000_000,
    parameter int          BAUD         = 115200,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dl_en_i,
    input  logic        rx_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    output logic        ack_valid_o,
    output logic [7:0]  ack_byte_o,
    input  logic        ack_ready_i,
    output logic        busy_o,
    output logic [7:0]  seq_o,
    output logic        err_o
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int TO_CYC  = TIMEOUT_BITS * BIT_CYC;
    localparam int TW      = $clog2(TO_CYC + 1);

    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ferr, rx_active;

    pkt_state_e  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [15:0] crc_q, crc_rx_q, crc_in, crc_nxt;
    logic [2:0]  widx_q;
    logic [7:0]  seq_q, ack_q;
    logic        retx_q, err_d;
    logic [TW-1:0] to_q;
    logic [7:0]  skid_q;
    logic        skid_v_q;
    logic [7:0]  buf_q [PAYLOAD_LEN+1];

    logic        take, in_v;
    logic [7:0]  in_b;
    logic        crc_ok, seq_hit, seq_old;
    logic [5:0]  wb;

    uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (!dl_en_i),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr),
        .active_o    (rx_active)
    );

    // Bytes landing while a packet is being written/answered wait in skid.
    assign take = (state_q == WAIT) || (state_q == RECV);
    assign in_v = take && (skid_v_q || rx_valid);
    assign in_b = skid_v_q ? skid_q : rx_byte;

    assign crc_in = (cnt_q == 6'd0) ? CRC_INIT : crc_q;

    crc16_modbus u_crc (
        .crc_i  (crc_in),
        .data_i (in_b),
        .crc_o  (crc_nxt)
    );

    assign crc_ok  = (crc_q == crc_rx_q);
    assign seq_hit = (buf_q[0] == seq_q);
    assign seq_old = (buf_q[0] == seq_q - 8'd1);

    always_comb begin
        state_d = state_q;
        err_d   = rx_ferr;
        unique case (state_q)
            WAIT: if (in_v && !rx_ferr) state_d = RECV;
            RECV: begin
                if (rx_ferr) begin
                    state_d = WAIT;
                end else if (in_v) begin
                    if (cnt_q == 6'(PKT_LEN - 1)) state_d = CHECK;
                end else if (to_q == TW'(TO_CYC - 1)) begin
                    state_d = WAIT;
                    err_d   = 1'b1;
                end
            end
            CHECK: begin
                if (crc_ok && (seq_hit || seq_old)) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            WRITE: if (mem_gnt_i && widx_q == 3'd7) state_d = RESP;
            RESP:  if (ack_ready_i) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WAIT;
            cnt_q    <= '0;
            crc_q    <= CRC_INIT;
            crc_rx_q <= '0;
            widx_q   <= '0;
            seq_q    <= '0;
            ack_q    <= '0;
            retx_q   <= 1'b0;
            to_q     <= '0;
            err_o    <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else if (!dl_en_i) begin
            state_q  <= WAIT;
            cnt_q    <= '0;
            widx_q   <= '0;
            seq_q    <= '0;
            to_q     <= '0;
            err_o    <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_o   <= err_d;

            if (take) skid_v_q <= skid_v_q && rx_valid;
            else if (rx_valid) skid_v_q <= 1'b1;
            if (rx_valid && (!take || skid_v_q)) skid_q <= rx_byte;

            if (in_v) begin
                cnt_q <= cnt_q + 6'd1;
                if (cnt_q < 6'(PAYLOAD_LEN + 1)) crc_q <= crc_nxt;
                if (cnt_q == 6'd33) crc_rx_q[7:0]  <= in_b;
                if (cnt_q == 6'd34) crc_rx_q[15:8] <= in_b;
            end
            if (state_d == WAIT) cnt_q <= '0;

            if (state_q == RECV && !in_v) to_q <= to_q + TW'(1);
            else to_q <= '0;

            if (state_q == CHECK) begin
                widx_q <= '0;
                retx_q <= !seq_hit;
                if (state_d == RESP) ack_q <= NAK;
            end

            if (state_q == WRITE && mem_gnt_i) begin
                widx_q <= widx_q + 3'd1;
                if (widx_q == 3'd7) begin
                    ack_q <= ACK;
                    if (!retx_q) seq_q <= seq_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (dl_en_i && in_v && cnt_q < 6'(PAYLOAD_LEN + 1))
            buf_q[cnt_q] <= in_b;
    end

    assign wb = {1'b0, widx_q, 2'b00} + 6'd1;

    assign mem_req_o   = (state_q == WRITE);
    assign mem_addr_o  = mem_req_o
        ? BASE_ADDR + {19'b0, buf_q[0], 5'b0} + {27'b0, widx_q, 2'b00}
        : '0;
    assign mem_wdata_o = mem_req_o
        ? {buf_q[wb+6'd3], buf_q[wb+6'd2], buf_q[wb+6'd1], buf_q[wb]}
        : '0;

    assign ack_valid_o = (state_q == RESP);
    assign ack_byte_o  = ack_valid_o ? ack_q : '0;
    assign busy_o      = (state_q != WAIT) || rx_active;
    assign seq_o       = seq_q;

endmodule
